adder_share_arb: RTL and testbench

- Shares a single 32-bit adder datapath (WIDTH-bit operands, WIDTH+1-bit sum including carry) among NUM_REQ requesters.
- Round-robin arbitration with valid/ready handshakes on every request port and on one shared response port.
- Registered result carries the winning requester ID.
- Sits between client blocks and the adder so only one adder instance is built.

---
 rtl/adder_share_arb_if.sv | 40 ++++
 rtl/adder_share_arb.sv | 101 ++++++++++
 tb/tb_adder_share_arb.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_share_arb_if.sv
// Request/response bundle for the shared adder arbiter.
// master = clients + consumer, slave = arbiter.
interface adder_share_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
);
  localparam int ID_W =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH:0]           rsp_sum;
  logic [ID_W-1:0]          rsp_id;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_sum,
    input  rsp_id
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_sum,
    output rsp_id
  );
endinterface

// File: rtl/adder_share_arb.sv
// Round-robin arbiter sharing one WIDTH-bit adder
// among NUM_REQ clients, with a one-deep result register.
module adder_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst,
  adder_share_arb_if.slave bus,
  output logic [15:0]      carry_cnt,
  output logic             busy
);
  localparam int ID_W =
    (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gnt;
  logic [ID_W-1:0]    ptr_nxt;
  logic               found;
  logic               free;
  logic               take;
  logic               rsp_hs;
  logic [NUM_REQ-1:0] ready;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic [WIDTH:0]     sum_d;
  logic [WIDTH:0]     sum_q;
  logic [ID_W-1:0]    id_q;

  // first valid requester scanning upward from ptr, wrapping
  always_comb begin
    int j;
    j     = 0;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ)
        j = j - NUM_REQ;
      if (!found && bus.req_valid[j]) begin
        found = 1'b1;
        gnt   = ID_W'(j);
      end
    end
  end

  assign rsp_hs = bus.rsp_valid && bus.rsp_ready;
  assign free   = (state == EMPTY) || rsp_hs;

  // one-hot accept for the winner when the slot can take it
  always_comb begin
    ready = '0;
    if (!rst && free && found)
      ready[gnt] = 1'b1;
  end

  assign bus.req_ready = ready;
  assign take = |(bus.req_valid & ready);

  assign a_sel = bus.req_a[int'(gnt)*WIDTH +: WIDTH];
  assign b_sel = bus.req_b[int'(gnt)*WIDTH +: WIDTH];
  assign sum_d = {1'b0, a_sel} + {1'b0, b_sel};

  assign ptr_nxt =
    (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;

  // result slot FSM, rr pointer and carry counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      sum_q     <= '0;
      id_q      <= '0;
      ptr       <= '0;
      carry_cnt <= '0;
    end else begin
      if (rsp_hs && sum_q[WIDTH] &&
          carry_cnt != 16'hFFFF)
        carry_cnt <= carry_cnt + 16'd1;
      if (take) begin
        state <= FULL;
        sum_q <= sum_d;
        id_q  <= gnt;
        ptr   <= ptr_nxt;
      end else if (rsp_hs) begin
        state <= EMPTY;
      end
    end
  end

  assign bus.rsp_valid = (state == FULL);
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_id    = id_q;
  assign busy = bus.rsp_valid || (|bus.req_valid);

endmodule

// File: tb/tb_adder_share_arb.sv
// Directed + random bench for adder_share_arb against
// a cycle-level behavioural model of the arbiter.
module tb_adder_share_arb;
  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] carry_cnt;
  logic        busy;

  logic [N-1:0] rv = '0;
  logic         rr = 1'b0;
  logic [W-1:0] a_op [N];
  logic [W-1:0] b_op [N];

  int errs  = 0;
  int total = 0;

  // model state
  int          mptr  = 0;
  bit          mfull = 0;
  logic [W:0]  msum  = '0;
  int          mid   = 0;
  int          mcar  = 0;

  adder_share_arb_if #(.NUM_REQ(N), .WIDTH(W)) ifc ();

  assign ifc.req_valid = rv;
  assign ifc.rsp_ready = rr;
  for (genvar i = 0; i < N; i++) begin : g_pack
    assign ifc.req_a[i*W +: W] = a_op[i];
    assign ifc.req_b[i*W +: W] = b_op[i];
  end

  adder_share_arb #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc.slave),
    .carry_cnt(carry_cnt),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag,
                     logic [63:0] obs,
                     logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] exp_ready();
    int i;
    if (rst) return '0;
    if (mfull && !rr) return '0;
    for (int k = 0; k < N; k++) begin
      i = (mptr + k) % N;
      if (rv[i]) return N'(1) << i;
    end
    return '0;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 3))
      0: return 32'hFFFF_FFFF;
      1: return 32'h0;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic req(int i, logic [W-1:0] x,
                     logic [W-1:0] y);
    rv[i]   = 1'b1;
    a_op[i] = x;
    b_op[i] = y;
  endtask

  // compare every output against the model
  task automatic settle();
    #1;
    chk("req_ready", 64'(ifc.req_ready),
        64'(exp_ready()));
    chk("rsp_valid", 64'(ifc.rsp_valid), 64'(mfull));
    chk("rsp_sum", 64'(ifc.rsp_sum), 64'(msum));
    chk("rsp_id", 64'(ifc.rsp_id), 64'(mid));
    chk("carry_cnt", 64'(carry_cnt), 64'(mcar));
    chk("busy", 64'(busy), 64'(mfull || (|rv)));
  endtask

  // advance one clock and apply the spec rules
  task automatic clock();
    logic [N-1:0] g1h;
    bit           rhs;
    int           g;
    g1h = exp_ready() & rv;
    rhs = mfull && rr;
    @(posedge clk);
    @(negedge clk);
    if (rst) begin
      mptr = 0; mfull = 0; msum = '0;
      mid = 0; mcar = 0;
    end else begin
      if (rhs && msum[W] && mcar < 65535)
        mcar++;
      if (g1h != 0) begin
        g = $clog2(g1h);
        msum  = {1'b0, a_op[g]} + {1'b0, b_op[g]};
        mid   = g;
        mfull = 1;
        mptr  = (g + 1) % N;
        rv[g] = 1'b0;
      end else if (rhs) begin
        mfull = 0;
      end
    end
  endtask

  task automatic cycle();
    settle();
    clock();
  endtask

  initial begin
    logic [W:0]      hold_sum;
    logic [N-1:0]    rv_new;
    for (int i = 0; i < N; i++) begin
      a_op[i] = '0;
      b_op[i] = '0;
    end
    @(negedge clk);
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;

    // idle after reset
    settle();
    chk("idle_valid", 64'(ifc.rsp_valid), 64'd0);
    chk("idle_ready", 64'(ifc.req_ready), 64'd0);
    chk("idle_carry", 64'(carry_cnt), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    clock();

    // single request
    rr = 1'b1;
    req(0, 32'd5, 32'd7);
    settle();
    chk("single_ready", 64'(ifc.req_ready), 64'h1);
    clock();
    settle();
    chk("single_valid", 64'(ifc.rsp_valid), 64'd1);
    chk("single_sum", 64'(ifc.rsp_sum), 64'd12);
    chk("single_id", 64'(ifc.rsp_id), 64'd0);
    clock();

    // reset, then all four valid continuously
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < N; i++)
        if (!rv[i]) req(i, rnd_op(), rnd_op());
      settle();
      chk("rr_grant", 64'(ifc.req_ready),
          64'(1) << (n % N));
      if (n > 0)
        chk("rr_id", 64'(ifc.rsp_id),
            64'((n - 1) % N));
      clock();
    end
    rv = '0;

    // backpressure: result held, 0110 waiting
    rr = 1'b0;
    req(1, 32'd100, 32'd1);
    req(2, 32'd200, 32'd2);
    settle();
    hold_sum = ifc.rsp_sum;
    clock();
    for (int n = 0; n < 3; n++) begin
      settle();
      chk("bp_ready", 64'(ifc.req_ready), 64'd0);
      chk("bp_sum", 64'(ifc.rsp_sum), 64'(hold_sum));
      chk("bp_id", 64'(ifc.rsp_id), 64'd0);
      clock();
    end
    rr = 1'b1;
    settle();
    chk("bp_g1", 64'(ifc.req_ready), 64'b0010);
    clock();
    settle();
    chk("bp_g2", 64'(ifc.req_ready), 64'b0100);
    chk("bp_id1", 64'(ifc.rsp_id), 64'd1);
    chk("bp_sum1", 64'(ifc.rsp_sum), 64'd101);
    clock();
    settle();
    chk("bp_id2", 64'(ifc.rsp_id), 64'd2);
    chk("bp_sum2", 64'(ifc.rsp_sum), 64'd202);
    clock();

    // carry handling
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    req(0, 32'hFFFF_FFFF, 32'h1);
    cycle();
    req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    settle();
    chk("carry_sum1", 64'(ifc.rsp_sum),
        64'h1_0000_0000);
    chk("carry_cnt0", 64'(carry_cnt), 64'd0);
    clock();
    settle();
    chk("carry_sum2", 64'(ifc.rsp_sum),
        64'h1_FFFF_FFFE);
    chk("carry_cnt1", 64'(carry_cnt), 64'd1);
    clock();
    settle();
    chk("carry_cnt2", 64'(carry_cnt), 64'd2);
    clock();

    // reset while full and stalled
    for (int i = 0; i < N; i++)
      req(i, rnd_op(), rnd_op());
    cycle();
    rr = 1'b0;
    for (int i = 0; i < N; i++)
      if (!rv[i]) req(i, rnd_op(), rnd_op());
    rst = 1'b1;
    settle();
    chk("rst_ready", 64'(ifc.req_ready), 64'd0);
    clock();
    rst = 1'b0;
    settle();
    chk("rst_valid", 64'(ifc.rsp_valid), 64'd0);
    chk("rst_carry", 64'(carry_cnt), 64'd0);
    chk("rst_grant0", 64'(ifc.req_ready), 64'h1);
    clock();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rr  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 59) == 0);
      rv_new = N'($urandom);
      for (int i = 0; i < N; i++)
        if (!rv[i] && rv_new[i])
          req(i, rnd_op(), rnd_op());
      cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks",
             errs, total);
    $finish;
  end

endmodule
